// File: rtl/ddma_tg_pkg.sv
// Shared types and helpers for the multi-flow DDMA traffic generator.
package ddma_tg_pkg;

  typedef enum logic [2:0] {IDLE, WR_HDR, WR_SIZE, CMD, WAIT} tg_state_e;

  localparam logic [1:0] CFG_PERIOD = 2'd0;
  localparam logic [1:0] CFG_OFFSET = 2'd1;
  localparam logic [1:0] CFG_NBYTES = 2'd2;
  localparam logic [1:0] CFG_ROUTE  = 2'd3;

  typedef struct packed {
    logic [7:0] tx;
    logic [7:0] ty;
    logic [7:0] sx;
    logic [7:0] sy;
  } route_t;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] offset;
    logic [31:0] nbytes;
    route_t      route;
  } flow_cfg_t;

  function automatic logic [31:0] pack_header(route_t r);
    return {r.tx, r.ty, r.sx, r.sy};
  endfunction

endpackage

// File: rtl/ddma_tg_rr_arbiter.sv
// Round-robin pick among requesting flows; the pointer moves past each taken grant.
module ddma_tg_rr_arbiter #(
  parameter int unsigned NUM_FLOWS = 4,
  localparam int unsigned FLOW_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_FLOWS-1:0] i_req,
  input  logic                 i_take,
  output logic                 o_valid,
  output logic [FLOW_W-1:0]    o_idx
);

  logic [FLOW_W-1:0] r_ptr;
  logic [FLOW_W-1:0] w_cand;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
      w_cand = FLOW_W'((32'(r_ptr) + i) % NUM_FLOWS);
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (i_take && o_valid) begin
      r_ptr <= (o_idx == FLOW_W'(NUM_FLOWS - 1)) ? '0 : o_idx + FLOW_W'(1);
    end
  end

endmodule

// File: rtl/ddma_traffic_gen.sv
// Periodic multi-flow packet generator: writes header/size flits to each flow's buffer,
// then issues a DDMA send and waits for its completion.
module ddma_traffic_gen
  import ddma_tg_pkg::*;
#(
  parameter int unsigned       NUM_FLOWS   = 4,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       CNT_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0] FLOW_STRIDE = ADDR_W'(32'h2000),
  localparam int unsigned      FLOW_W      = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [NUM_FLOWS-1:0] flow_en_i,
  input  logic                 cfg_we_i,
  input  logic [FLOW_W-1:0]    cfg_flow_i,
  input  logic [1:0]           cfg_sel_i,
  input  logic [31:0]          cfg_data_i,
  output logic                 mem_enable_o,
  output logic                 mem_wb_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [31:0]          mem_data_o,
  output logic                 ddma_cmd_valid_o,
  input  logic                 ddma_cmd_ready_i,
  output logic [ADDR_W-1:0]    ddma_addr_o,
  output logic [31:0]          ddma_nbytes_o,
  input  logic                 ddma_done_i,
  output logic                 busy_o,
  output logic [NUM_FLOWS-1:0] overrun_o
);

  tg_state_e            r_state, w_state_next;
  logic [CNT_W-1:0]     r_timer;
  flow_cfg_t            r_cfg [NUM_FLOWS];
  logic [NUM_FLOWS-1:0] r_armed, r_pending, r_overrun, w_pending_next, w_rel, w_req;
  logic                 w_take, w_gnt_valid;
  logic [FLOW_W-1:0]    w_gnt_idx;
  logic [ADDR_W-1:0]    r_base;
  logic [31:0]          r_nbytes;
  route_t               r_route;
  logic [32:0]          w_size_sum;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (start_i) begin
      r_timer <= r_timer + CNT_W'(1);
    end
  end

  // The offset field doubles as the running release time; armed gates one-shot flows.
  always_comb begin
    for (int f = 0; f < NUM_FLOWS; f++) begin
      w_rel[f] = start_i && flow_en_i[f] && r_armed[f] &&
                 (r_cfg[f].offset[CNT_W-1:0] == r_timer);
    end
  end

  // Same-cycle releases are visible to the arbiter so an idle engine grants immediately.
  assign w_req  = r_pending | w_rel;
  assign w_take = (r_state == IDLE) && w_gnt_valid;

  ddma_tg_rr_arbiter #(
    .NUM_FLOWS(NUM_FLOWS)
  ) u_arb (
    .clock  (clock),
    .reset  (reset),
    .i_req  (w_req),
    .i_take (w_take),
    .o_valid(w_gnt_valid),
    .o_idx  (w_gnt_idx)
  );

  always_comb begin
    w_pending_next = r_pending;
    for (int f = 0; f < NUM_FLOWS; f++) begin
      if (w_rel[f]) w_pending_next[f] = 1'b1;
      if (w_take && (w_gnt_idx == FLOW_W'(f))) w_pending_next[f] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < NUM_FLOWS; f++) r_cfg[f] <= '0;
      r_armed   <= '0;
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        if (w_rel[f]) begin
          r_cfg[f].offset <= r_cfg[f].offset + r_cfg[f].period;
          if (r_cfg[f].period[CNT_W-1:0] == '0) r_armed[f] <= 1'b0;
          if (r_pending[f]) r_overrun[f] <= 1'b1;
        end
        if (cfg_we_i && (cfg_flow_i == FLOW_W'(f))) begin
          unique case (cfg_sel_i)
            CFG_PERIOD: r_cfg[f].period <= cfg_data_i;
            CFG_OFFSET: begin
              r_cfg[f].offset <= cfg_data_i;
              r_armed[f]      <= 1'b1;
            end
            CFG_NBYTES: r_cfg[f].nbytes <= cfg_data_i;
            CFG_ROUTE:  r_cfg[f].route  <= route_t'(cfg_data_i);
            default: ;
          endcase
        end
      end
      r_pending <= w_pending_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_base   <= '0;
      r_nbytes <= '0;
      r_route  <= '0;
    end else if (w_take) begin
      r_base   <= BASE_ADDR + FLOW_STRIDE * ADDR_W'(w_gnt_idx);
      r_nbytes <= r_cfg[w_gnt_idx].nbytes;
      r_route  <= r_cfg[w_gnt_idx].route;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_take) w_state_next = WR_HDR;
      WR_HDR:  w_state_next = WR_SIZE;
      WR_SIZE: w_state_next = CMD;
      CMD:     if (ddma_cmd_ready_i) w_state_next = WAIT;
      WAIT:    if (ddma_done_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_size_sum = {1'b0, r_nbytes} + 33'd3;

  always_comb begin
    mem_enable_o     = 1'b0;
    mem_wb_o         = 1'b0;
    mem_addr_o       = '0;
    mem_data_o       = '0;
    ddma_cmd_valid_o = 1'b0;
    ddma_addr_o      = '0;
    ddma_nbytes_o    = '0;
    case (r_state)
      WR_HDR: begin
        mem_enable_o = 1'b1;
        mem_wb_o     = 1'b1;
        mem_addr_o   = r_base;
        mem_data_o   = pack_header(r_route);
      end
      WR_SIZE: begin
        mem_enable_o = 1'b1;
        mem_wb_o     = 1'b1;
        mem_addr_o   = r_base + ADDR_W'(4);
        mem_data_o   = {1'b0, w_size_sum[32:2]};
      end
      CMD: begin
        ddma_cmd_valid_o = 1'b1;
        ddma_addr_o      = r_base;
        ddma_nbytes_o    = r_nbytes;
      end
      default: ;
    endcase
  end

  assign busy_o    = (r_state != IDLE);
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_ddma_traffic_gen.sv
// Scoreboard bench: directed flows push expected flits/commands; a monitor pops and compares.
module tb_ddma_traffic_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  flow_en_i = '0;
  logic        cfg_we_i = 1'b0;
  logic [1:0]  cfg_flow_i = '0;
  logic [1:0]  cfg_sel_i = '0;
  logic [31:0] cfg_data_i = '0;
  logic        mem_enable_o, mem_wb_o, ddma_cmd_valid_o, busy_o;
  logic [31:0] mem_addr_o, mem_data_o, ddma_addr_o, ddma_nbytes_o;
  logic        ddma_cmd_ready_i = 1'b1;
  logic        ddma_done_i = 1'b0;
  logic [3:0]  overrun_o;

  typedef struct {
    bit          is_cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  t;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_delay = 20;
  logic [7:0] tb_t;

  ddma_traffic_gen #(
    .NUM_FLOWS(4),
    .CNT_W    (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start_i         (start_i),
    .flow_en_i       (flow_en_i),
    .cfg_we_i        (cfg_we_i),
    .cfg_flow_i      (cfg_flow_i),
    .cfg_sel_i       (cfg_sel_i),
    .cfg_data_i      (cfg_data_i),
    .mem_enable_o    (mem_enable_o),
    .mem_wb_o        (mem_wb_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_o      (mem_data_o),
    .ddma_cmd_valid_o(ddma_cmd_valid_o),
    .ddma_cmd_ready_i(ddma_cmd_ready_i),
    .ddma_addr_o     (ddma_addr_o),
    .ddma_nbytes_o   (ddma_nbytes_o),
    .ddma_done_i     (ddma_done_i),
    .busy_o          (busy_o),
    .overrun_o       (overrun_o)
  );

  always #5 clock = ~clock;

  // Bench-side cycle stamp: equals the release timer value during each cycle.
  always @(posedge clock or negedge reset) begin
    if (!reset) tb_t <= '0;
    else if (start_i) tb_t <= tb_t + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0d)", name, act, exp, tb_t);
    end
  endtask

  task automatic take_event(input bit is_cmd, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h at t=%0d, want none",
               is_cmd, a, d, tb_t);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 32'(is_cmd), 32'(e.is_cmd));
    check("event_addr", a, e.addr);
    check("event_data", d, e.data);
    check("event_cycle", 32'(tb_t), 32'(e.t));
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        if (mem_enable_o && mem_wb_o) take_event(1'b0, mem_addr_o, mem_data_o);
        if (ddma_cmd_valid_o && ddma_cmd_ready_i) take_event(1'b1, ddma_addr_o, ddma_nbytes_o);
      end
    end
  end

  // DDMA model: pulses done a fixed number of cycles after each accept, abandoned on reset.
  initial begin
    bit aborted;
    forever begin
      @(negedge clock);
      if (reset && ddma_cmd_valid_o && ddma_cmd_ready_i) begin
        aborted = 1'b0;
        for (int i = 0; i < done_delay; i++) begin
          @(posedge clock);
          if (!reset) aborted = 1'b1;
        end
        if (!aborted && reset) begin
          #1 ddma_done_i = 1'b1;
          @(posedge clock);
          #1 ddma_done_i = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    start_i = 1'b0;
    flow_en_i = '0;
    cfg_we_i = 1'b0;
    ddma_cmd_ready_i = 1'b1;
    exp_q.delete();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(input int f, input logic [1:0] sel, input logic [31:0] d);
    cfg_we_i = 1'b1;
    cfg_flow_i = 2'(f);
    cfg_sel_i = sel;
    cfg_data_i = d;
    @(posedge clock);
    #1 cfg_we_i = 1'b0;
  endtask

  task automatic set_flow(input int f, input logic [31:0] period, input logic [31:0] offset,
                          input logic [31:0] nbytes, input logic [31:0] route);
    cfg(f, 2'd0, period);
    cfg(f, 2'd1, offset);
    cfg(f, 2'd2, nbytes);
    cfg(f, 2'd3, route);
  endtask

  // tg is the grant cycle: header, size and command follow in the next three cycles.
  task automatic expect_pkt(input logic [31:0] base, input logic [31:0] hdr,
                            input logic [31:0] size, input logic [31:0] nbytes,
                            input logic [7:0] tg, input logic [7:0] stall);
    ev_t e;
    e.is_cmd = 1'b0; e.addr = base;      e.data = hdr;    e.t = tg + 8'd1;
    exp_q.push_back(e);
    e.is_cmd = 1'b0; e.addr = base + 4;  e.data = size;   e.t = tg + 8'd2;
    exp_q.push_back(e);
    e.is_cmd = 1'b1; e.addr = base;      e.data = nbytes; e.t = tg + 8'd3 + stall;
    exp_q.push_back(e);
  endtask

  task automatic run_to(input logic [7:0] t);
    int n = 0;
    while (tb_t != t && n < 600) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (tb_t != t) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_to: timer %0d, want %0d", tb_t, t);
    end
  endtask

  task automatic go(input logic [3:0] en);
    flow_en_i = en;
    start_i = 1'b1;
  endtask

  initial begin
    int busy_seen;

    // Reset state
    #1;
    check("reset_ctrl", 32'({mem_enable_o, mem_wb_o, ddma_cmd_valid_o, busy_o, overrun_o}), 0);
    do_reset();

    // Single periodic flow
    done_delay = 20;
    set_flow(0, 100, 10, 8192, 32'h02010103);
    expect_pkt(32'h0, 32'h02010103, 2048, 8192, 8'd10, 8'd0);
    expect_pkt(32'h0, 32'h02010103, 2048, 8192, 8'd110, 8'd0);
    expect_pkt(32'h0, 32'h02010103, 2048, 8192, 8'd210, 8'd0);
    go(4'b0001);
    run_to(8'd240);
    check("single_flow_drained", 32'(exp_q.size()), 0);
    do_reset();

    // Round-robin between simultaneous releases
    done_delay = 5;
    set_flow(0, 100, 50, 4, 32'h11223344);
    set_flow(1, 100, 50, 4, 32'h55667788);
    expect_pkt(32'h0,    32'h11223344, 1, 4, 8'd50,  8'd0);
    expect_pkt(32'h2000, 32'h55667788, 1, 4, 8'd59,  8'd0);
    expect_pkt(32'h0,    32'h11223344, 1, 4, 8'd150, 8'd0);
    expect_pkt(32'h2000, 32'h55667788, 1, 4, 8'd159, 8'd0);
    go(4'b0011);
    run_to(8'd175);
    check("rr_drained", 32'(exp_q.size()), 0);
    check("rr_no_overrun", 32'(overrun_o), 0);
    do_reset();

    // Overrun: release at 70 finds the 40 release still pending
    done_delay = 80;
    set_flow(0, 30, 10, 16, 32'h01020304);
    expect_pkt(32'h0, 32'h01020304, 4, 16, 8'd10, 8'd0);
    expect_pkt(32'h0, 32'h01020304, 4, 16, 8'd94, 8'd0);
    go(4'b0001);
    run_to(8'd110);
    check("overrun_flag", 32'(overrun_o), 32'h1);
    check("overrun_drained", 32'(exp_q.size()), 0);
    do_reset();

    // Backpressure: ready low for the first 5 cycles of valid
    done_delay = 5;
    ddma_cmd_ready_i = 1'b0;
    set_flow(2, 0, 5, 100, 32'hCAFEF00D);
    expect_pkt(32'h4000, 32'hCAFEF00D, 25, 100, 8'd5, 8'd5);
    go(4'b0100);
    run_to(8'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_valid", 32'(ddma_cmd_valid_o), 1);
      check("bp_addr", ddma_addr_o, 32'h4000);
      check("bp_nbytes", ddma_nbytes_o, 100);
      @(posedge clock);
      #1;
    end
    ddma_cmd_ready_i = 1'b1;
    run_to(8'd40);
    check("bp_drained", 32'(exp_q.size()), 0);
    do_reset();

    // Odd size, zero size, one-shot flows across a timer wrap
    done_delay = 5;
    set_flow(3, 0, 20, 10, 32'h03030303);
    set_flow(2, 0, 60, 0, 32'h02020202);
    expect_pkt(32'h6000, 32'h03030303, 3, 10, 8'd20, 8'd0);
    expect_pkt(32'h4000, 32'h02020202, 0, 0, 8'd60, 8'd0);
    go(4'b1100);
    run_to(8'd250);
    run_to(8'd80);
    check("oneshot_drained", 32'(exp_q.size()), 0);
    do_reset();

    // Release time that wraps modulo 2^8
    done_delay = 5;
    set_flow(1, 20, 254, 7, 32'hA0B0C0D0);
    expect_pkt(32'h2000, 32'hA0B0C0D0, 2, 7, 8'd254, 8'd0);
    expect_pkt(32'h2000, 32'hA0B0C0D0, 2, 7, 8'd18, 8'd0);
    go(4'b0010);
    run_to(8'd250);
    run_to(8'd30);
    check("wrap_drained", 32'(exp_q.size()), 0);
    do_reset();

    // Reset asserted while waiting for done
    done_delay = 100;
    set_flow(0, 5, 10, 8, 32'h0);
    expect_pkt(32'h0, 32'h0, 2, 8, 8'd10, 8'd0);
    go(4'b0001);
    run_to(8'd22);
    check("pre_reset_overrun", 32'(overrun_o), 32'h1);
    check("pre_reset_busy", 32'(busy_o), 1);
    check("pre_reset_drained", 32'(exp_q.size()), 0);
    reset = 1'b0;
    #1;
    check("async_reset_ctrl",
          32'({mem_enable_o, mem_wb_o, ddma_cmd_valid_o, busy_o, overrun_o}), 0);
    check("async_reset_data", mem_addr_o | mem_data_o | ddma_addr_o | ddma_nbytes_o, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (busy_o) busy_seen++;
    end
    check("post_reset_idle_cycles", 32'(busy_seen), 0);
    check("post_reset_overrun", 32'(overrun_o), 0);
    start_i = 1'b0;
    repeat (2) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
